// File: rtl/fetch_pkg.sv
// Shared types and defaults for the IF-stage fetch sequencer.
// State encoding plus reset PC and increment defaults.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_INC   = 32'd4;

endpackage

// File: rtl/pc_fetch_unit_add.sv
// Team 32-bit ripple-carry adder used for PC+4.
// Purely combinational; no carry-out, so sums wrap modulo 2^32.
module Add (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S
);

  logic c;

  always_comb begin
    c = 1'b0;
    S = '0;
    for (int i = 0; i < 32; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: PC register and single-outstanding fetch sequencer.
// Hands instr/pc/pc+4 to decode over a valid/ready handshake.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_INC   = DEF_PC_INC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        drop, drop_n;
  logic        cap;
  logic [31:0] sum;
  logic [31:0] target;

  Add u_add (
    .A(pc),
    .B(PC_INC),
    .S(sum)
  );

  assign target    = redirect_pc & ~32'h3;
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign if_valid  = (state == S_HOLD);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    cap     = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (redirect_valid) pc_n = target;
      end
      S_REQ: begin
        if (redirect_valid) pc_n = target;
        if (imem_gnt) begin
          state_n = S_WAIT;
          drop_n  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) pc_n = target;
        if (imem_rvalid) begin
          drop_n = 1'b0;
          if (drop || redirect_valid) begin
            state_n = S_REQ;
          end else begin
            cap     = 1'b1;
            state_n = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_n = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect wins over the handshake: the held word is squashed.
        if (redirect_valid) begin
          pc_n    = target;
          state_n = S_REQ;
        end else if (if_ready) begin
          pc_n    = sum;
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
      if (cap) begin
        if_instr    <= imem_rdata;
        if_pc       <= pc;
        if_pc_plus4 <= sum;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Second instance uses a wrap-around reset PC.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc_plus4;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;

  int nvec = 0;
  int nbad = 0;

  always #5000 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(w_valid), .if_ready(if_ready),
    .if_instr(w_instr), .if_pc(w_pc),
    .if_pc_plus4(w_pc4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in S_REQ with idle inputs; leaves in S_REQ at a+4.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    chk("req", {31'b0, imem_req}, 1);
    chk("addr", imem_addr, a);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_req", {31'b0, imem_req}, 0);
    chk("wait_v", {31'b0, if_valid}, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    step();
    imem_rvalid = 1'b0;
    chk("hold_v", {31'b0, if_valid}, 1);
    chk("instr", if_instr, d);
    chk("pc", if_pc, a);
    chk("pc4", if_pc_plus4, a + 32'd4);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("post_v", {31'b0, if_valid}, 0);
  endtask

  initial begin
    reset = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_v", {31'b0, if_valid}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_pc4", if_pc_plus4, 0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFFC);
    reset = 1'b0;
    step();

    // 1: sequential fetches
    fetch(32'h0, 32'h1111_0000);
    fetch(32'h4, 32'h1111_0004);
    fetch(32'h8, 32'h1111_0008);
    fetch(32'hC, 32'h1111_000C);

    // 2: decode stalls in S_HOLD
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hCAFE_0010;
    step();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_v", {31'b0, if_valid}, 1);
      chk("stall_instr", if_instr, 32'hCAFE_0010);
      chk("stall_pc", if_pc, 32'h10);
      chk("stall_req", {31'b0, imem_req}, 0);
      step();
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("stall_next", imem_addr, 32'h14);
    chk("stall_nreq", {31'b0, imem_req}, 1);

    // 3: grant withheld
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nognt_req", {31'b0, imem_req}, 1);
      chk("nognt_addr", imem_addr, 32'h14);
      chk("nognt_v", {31'b0, if_valid}, 0);
    end
    fetch(32'h14, 32'h2222_0014);

    // 4: redirect during S_WAIT, stale data dropped
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("rw_req", {31'b0, imem_req}, 0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("rw_v", {31'b0, if_valid}, 0);
    fetch(32'h100, 32'h3333_0100);

    // 5: redirect in S_HOLD with if_ready
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h4444_0104;
    step();
    imem_rvalid = 1'b0;
    chk("rh_hold", {31'b0, if_valid}, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    if_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    chk("rh_v", {31'b0, if_valid}, 0);
    fetch(32'h200, 32'h5555_0200);

    // redirect in S_REQ without grant
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0302;
    step();
    redirect_valid = 1'b0;
    chk("rq_req", {31'b0, imem_req}, 1);
    chk("rq_addr", imem_addr, 32'h300);

    // 6: reset during S_WAIT, then wrap-around instance
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    reset = 1'b1;
    step();
    chk("rs_req", {31'b0, imem_req}, 0);
    chk("rs_v", {31'b0, if_valid}, 0);
    chk("rs_addr", imem_addr, 0);
    chk("rs_instr", if_instr, 0);
    chk("rs_pc", if_pc, 0);
    chk("rs_pc4", if_pc_plus4, 0);
    reset = 1'b0;
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h7777_7777;
    step();
    imem_rvalid = 1'b0;
    chk("late_req", {31'b0, imem_req}, 1);
    chk("late_v", {31'b0, if_valid}, 0);
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h8888_8888;
    step();
    imem_rvalid = 1'b0;
    chk("w_v", {31'b0, w_valid}, 1);
    chk("w_pc", w_pc, 32'hFFFF_FFFC);
    chk("w_pc4", w_pc4, 32'h0);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    chk("w_addr1", w_addr, 32'h0);
    chk("w_req1", {31'b0, w_req}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
